guess_rx_ctrl: RTL and testbench
================================

Name: guess_rx_ctrl

Overview:
Controller that sequences the UART receive path for a single guess entry. It gates the receiver with rec_ready, classifies each received byte (letter, backspace, enter, invalid), and assembles a WORD_LEN-letter guess. It hands the completed word to the game logic through a valid/ack handshake and converts receiver framing errors into a timed error indication. It sits between the UART_Rx/Buffer pair and the game FSM.

Parameters:
WORD_LEN, 5, letters per guess (1..7)
ERR_HOLD, 1000000, cycles err_LED stays high after a receive error (>=1)

Ports:
clk  input  1  system clock
Rst  input  1  synchronous active-high reset
rx_ready  input  1  one-cycle pulse, rx_byte valid
rx_byte  input  8  received byte
rx_err  input  1  framing/parity error pulse from receiver
game_rdy  input  1  game accepts guess entry
word_ack  input  1  game consumed word
rec_ready  output  1  receiver enable
word  output  8*WORD_LEN  packed guess, slot i at [8i+7:8i], slot 0 = first letter
word_valid  output  1  word complete, held until word_ack
letter_cnt  output  3  letters currently held
bad_char  output  1  one-cycle pulse on rejected byte
err_LED  output  1  error indicator

Behaviour:
- One clock, synchronous active-high reset. All state updates occur on rising clk.
- Reset: state=IDLE, word=0, letter_cnt=0, word_valid=0, rec_ready=0, bad_char=0, err_LED=0, error counter=0. Reset asserted mid-word discards the partial word.
- States: IDLE, COLLECT, SUBMIT, ERROR.
- Outputs are registered. Every effect appears the cycle after the triggering input.
- IDLE: rec_ready=0; rx_ready and rx_err ignored; game_rdy=1 -> COLLECT.
- COLLECT: rec_ready=1. Priority, highest first:
  1. rx_err=1 -> ERROR; clear word and letter_cnt; any byte presented in the same cycle is discarded.
  2. game_rdy=0 -> IDLE; clear word and letter_cnt.
  3. rx_ready=1: classify rx_byte.
     - 0x61-0x7A (lowercase letter): if letter_cnt<WORD_LEN, store in slot letter_cnt and increment letter_cnt; else drop and pulse bad_char.
     - 0x41-0x5A (uppercase letter): converted to lowercase (+0x20), then handled as a lowercase letter.
     - 0x08 or 0x7F (backspace): if letter_cnt>0, decrement letter_cnt and zero the vacated slot; at 0 it is a no-op with no bad_char.
     - 0x0D (enter): if letter_cnt==WORD_LEN -> SUBMIT; else pulse bad_char, no state change.
     - Any other byte: pulse bad_char.
- SUBMIT:
  - rec_ready=0, word_valid=1; word and letter_cnt are held stable.
  - On word_ack=1: word_valid=0, word=0, letter_cnt=0, then go to COLLECT if game_rdy=1, else IDLE.
  - game_rdy dropping in SUBMIT does not abort; the word remains valid until acked.
  - rx_ready and rx_err are ignored.
- ERROR:
  - rec_ready=0, err_LED=1.
  - The counter loads ERR_HOLD-1 on entry and decrements each cycle; at 0 the block goes to IDLE and err_LED falls the same edge.
  - err_LED is therefore high for exactly ERR_HOLD cycles. rx_err re-asserted during ERROR does not restart the count.
- bad_char is never high for two consecutive cycles unless rejected bytes arrive on consecutive cycles.
- letter_cnt is never greater than WORD_LEN.

Optional Feature:
GUESS_RX_ECHO_EN:
- When defined, adds two outputs: echo_byte (8 bits) and echo_valid (1 bit, one-cycle pulse).
- echo_valid pulses the cycle after any accepted letter, with echo_byte = uppercase form of the letter (0x41-0x5A).
- echo_valid pulses after an effective backspace, with echo_byte=0x08.
- No echo for rejected bytes, no-op backspaces, or enter.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, game_rdy=1, send 'c','r','a','n','e', 0x0D -> rec_ready=1 from cycle 2; letter_cnt steps 1..5; word_valid=1 with word=0x656E617263; word_ack -> word=0, letter_cnt=0, back in COLLECT.
2. Send 'A','b', 0x08, 'Z' -> slot0=0x61, slot1=0x7A, letter_cnt=2; no bad_char.
3. Send 0x0D with 3 letters, then a 6th letter after 5, then '1' -> bad_char pulses 3 times; word unchanged; state stays COLLECT.
4. rx_err and rx_ready in the same cycle with 2 letters held -> ERROR; word=0; err_LED high exactly ERR_HOLD cycles (ERR_HOLD=4 in the bench), then IDLE; rx_ready during ERROR ignored.
5. game_rdy dropped mid-word -> IDLE next cycle, letter_cnt=0. game_rdy dropped in SUBMIT -> word_valid held until word_ack, then IDLE.
6. Rst asserted during SUBMIT -> all outputs 0 next cycle. With GUESS_RX_ECHO_EN: 'q' -> echo_byte=0x51, echo_valid one-cycle pulse.

Source files
------------

// File: rtl/guess_rx_ctrl.sv
// guess_rx_ctrl: sequences the UART receive path for one guess entry.
// Gates the receiver, classifies received bytes, assembles a WORD_LEN-letter
// guess, hands it to the game through a valid/ack handshake and turns receiver
// errors into a timed err_LED indication.
// Optional build macro GUESS_RX_ECHO_EN adds echo_byte/echo_valid outputs that
// echo accepted letters (uppercase) and effective backspaces (0x08).

module guess_rx_ctrl #(
  parameter int unsigned WORD_LEN = 5,
  parameter int unsigned ERR_HOLD = 1000000
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_err,
  input  logic                  game_rdy,
  input  logic                  word_ack,
  output logic                  rec_ready,
  output logic [8*WORD_LEN-1:0] word,
  output logic                  word_valid,
  output logic [2:0]            letter_cnt,
  output logic                  bad_char,
  output logic                  err_LED
`ifdef GUESS_RX_ECHO_EN
  ,
  output logic [7:0]            echo_byte,
  output logic                  echo_valid
`endif
);

  localparam int unsigned CntW     = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam logic [CntW-1:0] HoldInit = CntW'(ERR_HOLD - 1);
  localparam logic [2:0]      WordLenC = 3'(WORD_LEN);

  typedef enum logic [1:0] {StIdle, StCollect, StSubmit, StError} state_e;

  state_e          state;
  logic [CntW-1:0] err_cnt;

  logic       is_lower;
  logic       is_upper;
  logic       is_letter;
  logic       is_bs;
  logic       is_enter;
  logic [7:0] lc_byte;

  // Byte classification; uppercase letters are folded to lowercase before storage.
  always_comb begin
    is_lower  = (rx_byte >= 8'h61) && (rx_byte <= 8'h7A);
    is_upper  = (rx_byte >= 8'h41) && (rx_byte <= 8'h5A);
    is_letter = is_lower || is_upper;
    is_bs     = (rx_byte == 8'h08) || (rx_byte == 8'h7F);
    is_enter  = (rx_byte == 8'h0D);
    lc_byte   = is_upper ? (rx_byte + 8'h20) : rx_byte;
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state      <= StIdle;
      err_cnt    <= '0;
      rec_ready  <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      letter_cnt <= 3'd0;
      bad_char   <= 1'b0;
      err_LED    <= 1'b0;
`ifdef GUESS_RX_ECHO_EN
      echo_byte  <= 8'h00;
      echo_valid <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      bad_char <= 1'b0;
`ifdef GUESS_RX_ECHO_EN
      echo_valid <= 1'b0;
`endif
      case (state)
        StIdle: begin
          if (game_rdy) begin
            state     <= StCollect;
            rec_ready <= 1'b1;
          end
        end

        StCollect: begin
          if (rx_err) begin
            // Error wins over any byte presented in the same cycle.
            state      <= StError;
            rec_ready  <= 1'b0;
            err_LED    <= 1'b1;
            err_cnt    <= HoldInit;
            word       <= '0;
            letter_cnt <= 3'd0;
          end else if (!game_rdy) begin
            state      <= StIdle;
            rec_ready  <= 1'b0;
            word       <= '0;
            letter_cnt <= 3'd0;
          end else if (rx_ready) begin
            if (is_letter) begin
              if (letter_cnt < WordLenC) begin
                for (int i = 0; i < int'(WORD_LEN); i++) begin
                  if (i == int'(letter_cnt)) word[8*i +: 8] <= lc_byte;
                end
                letter_cnt <= letter_cnt + 3'd1;
`ifdef GUESS_RX_ECHO_EN
                echo_byte  <= lc_byte - 8'h20;
                echo_valid <= 1'b1;
`endif
              end else begin
                bad_char <= 1'b1;
              end
            end else if (is_bs) begin
              // Backspace on an empty guess is silently ignored.
              if (letter_cnt != 3'd0) begin
                for (int i = 0; i < int'(WORD_LEN); i++) begin
                  if (i == int'(letter_cnt) - 1) word[8*i +: 8] <= 8'h00;
                end
                letter_cnt <= letter_cnt - 3'd1;
`ifdef GUESS_RX_ECHO_EN
                echo_byte  <= 8'h08;
                echo_valid <= 1'b1;
`endif
              end
            end else if (is_enter) begin
              if (letter_cnt == WordLenC) begin
                state      <= StSubmit;
                rec_ready  <= 1'b0;
                word_valid <= 1'b1;
              end else begin
                bad_char <= 1'b1;
              end
            end else begin
              bad_char <= 1'b1;
            end
          end
        end

        StSubmit: begin
          // Only word_ack leaves SUBMIT; game_rdy is consulted just to pick the exit.
          if (word_ack) begin
            word_valid <= 1'b0;
            word       <= '0;
            letter_cnt <= 3'd0;
            if (game_rdy) begin
              state     <= StCollect;
              rec_ready <= 1'b1;
            end else begin
              state <= StIdle;
            end
          end
        end

        StError: begin
          // Count is not restarted by further rx_err; err_LED drops on the exit edge.
          if (err_cnt == '0) begin
            state   <= StIdle;
            err_LED <= 1'b0;
          end else begin
            err_cnt <= err_cnt - 1'b1;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_rx_ctrl.sv
// Directed self-checking bench for guess_rx_ctrl (WORD_LEN=5, ERR_HOLD=4).
module tb_guess_rx_ctrl;

  logic        clk = 1'b0;
  logic        Rst;
  logic        rx_ready;
  logic [7:0]  rx_byte;
  logic        rx_err;
  logic        game_rdy;
  logic        word_ack;
  logic        rec_ready;
  logic [39:0] word;
  logic        word_valid;
  logic [2:0]  letter_cnt;
  logic        bad_char;
  logic        err_LED;
`ifdef GUESS_RX_ECHO_EN
  logic [7:0]  echo_byte;
  logic        echo_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  guess_rx_ctrl #(
    .WORD_LEN(5),
    .ERR_HOLD(4)
  ) dut (
    .clk       (clk),
    .Rst       (Rst),
    .rx_ready  (rx_ready),
    .rx_byte   (rx_byte),
    .rx_err    (rx_err),
    .game_rdy  (game_rdy),
    .word_ack  (word_ack),
    .rec_ready (rec_ready),
    .word      (word),
    .word_valid(word_valid),
    .letter_cnt(letter_cnt),
    .bad_char  (bad_char),
    .err_LED   (err_LED)
`ifdef GUESS_RX_ECHO_EN
    ,
    .echo_byte (echo_byte),
    .echo_valid(echo_valid)
`endif
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_byte  = b;
    step();
    rx_ready = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic test_reset();
    Rst = 1'b1; rx_ready = 1'b0; rx_byte = 8'h00; rx_err = 1'b0;
    game_rdy = 1'b0; word_ack = 1'b0;
    step(); step();
    Rst = 1'b0;
    checks++;
    if ({rec_ready, word_valid, bad_char, err_LED} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {rec_ready, word_valid, bad_char, err_LED});
    end
    checks++;
    if (word !== 40'h0 || letter_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_word got word=%h cnt=%0d want 0/0", word, letter_cnt);
    end
  endtask

  task automatic test_submit();
    logic [7:0] letters [5] = '{8'h63, 8'h72, 8'h61, 8'h6E, 8'h65};
    game_rdy = 1'b1;
    step();
    checks++;
    if (rec_ready !== 1'b1) begin
      errors++;
      $display("FAIL submit_rec_ready got %b want 1", rec_ready);
    end
    for (int i = 0; i < 5; i++) begin
      send(letters[i]);
      checks++;
      if (letter_cnt !== 3'(i + 1)) begin
        errors++;
        $display("FAIL submit_cnt got %0d want %0d", letter_cnt, i + 1);
      end
    end
    send(8'h0D);
    checks++;
    if (word_valid !== 1'b1 || word !== 40'h656E617263 || rec_ready !== 1'b0) begin
      errors++;
      $display("FAIL submit_word got v=%b w=%h rr=%b want 1 656e617263 0",
               word_valid, word, rec_ready);
    end
    step();
    checks++;
    if (word_valid !== 1'b1 || word !== 40'h656E617263) begin
      errors++;
      $display("FAIL submit_hold got v=%b w=%h want 1 656e617263", word_valid, word);
    end
    word_ack = 1'b1;
    step();
    word_ack = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || word !== 40'h0 || letter_cnt !== 3'd0 || rec_ready !== 1'b1) begin
      errors++;
      $display("FAIL submit_ack got v=%b w=%h cnt=%0d rr=%b want 0 0 0 1",
               word_valid, word, letter_cnt, rec_ready);
    end
  endtask

  task automatic test_backspace();
    logic [7:0] seq [4] = '{8'h41, 8'h62, 8'h08, 8'h5A};
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      send(seq[i]);
      if (bad_char) bad++;
    end
    checks++;
    if (word !== 40'h7A61 || letter_cnt !== 3'd2 || bad != 0) begin
      errors++;
      $display("FAIL backspace got w=%h cnt=%0d bad=%0d want 7a61 2 0", word, letter_cnt, bad);
    end
  endtask

  task automatic test_bad_char();
    int bad = 0;
    send(8'h78);
    send(8'h0D);
    if (bad_char) bad++;
    checks++;
    if (letter_cnt !== 3'd3 || word_valid !== 1'b0 || rec_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_enter got cnt=%0d v=%b rr=%b want 3 0 1", letter_cnt, word_valid, rec_ready);
    end
    step();
    checks++;
    if (bad_char !== 1'b0) begin
      errors++;
      $display("FAIL bad_pulse_width got %b want 0", bad_char);
    end
    send(8'h79);
    send(8'h7A);
    send(8'h71);
    if (bad_char) bad++;
    send(8'h31);
    if (bad_char) bad++;
    checks++;
    if (bad != 3 || letter_cnt !== 3'd5 || word !== 40'h7A79787A61 || rec_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_overflow got bad=%0d cnt=%0d w=%h rr=%b want 3 5 7a79787a61 1",
               bad, letter_cnt, word, rec_ready);
    end
    // Back down to two letters for the error scenario.
    send(8'h7F);
    send(8'h08);
    send(8'h08);
    checks++;
    if (word !== 40'h7A61 || letter_cnt !== 3'd2) begin
      errors++;
      $display("FAIL bad_trim got w=%h cnt=%0d want 7a61 2", word, letter_cnt);
    end
  endtask

  task automatic test_error();
    int n = 1;
    rx_err = 1'b1; rx_ready = 1'b1; rx_byte = 8'h6B;
    step();
    rx_err = 1'b0; rx_ready = 1'b0;
    checks++;
    if (err_LED !== 1'b1 || word !== 40'h0 || letter_cnt !== 3'd0 || rec_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_entry got led=%b w=%h cnt=%0d rr=%b want 1 0 0 0",
               err_LED, word, letter_cnt, rec_ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin rx_ready = 1'b1; rx_byte = 8'h6D; rx_err = 1'b1; end
      step();
      rx_ready = 1'b0; rx_err = 1'b0;
      if (!err_LED) break;
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL err_hold got %0d cycles want 4", n);
    end
    checks++;
    if (rec_ready !== 1'b0 || letter_cnt !== 3'd0 || word !== 40'h0) begin
      errors++;
      $display("FAIL err_exit got rr=%b cnt=%0d w=%h want 0 0 0", rec_ready, letter_cnt, word);
    end
    step();
    checks++;
    if (rec_ready !== 1'b1 || err_LED !== 1'b0) begin
      errors++;
      $display("FAIL err_recollect got rr=%b led=%b want 1 0", rec_ready, err_LED);
    end
  endtask

  task automatic test_game_rdy_drop();
    send(8'h61);
    send(8'h62);
    game_rdy = 1'b0;
    step();
    checks++;
    if (rec_ready !== 1'b0 || letter_cnt !== 3'd0 || word !== 40'h0) begin
      errors++;
      $display("FAIL drop_collect got rr=%b cnt=%0d w=%h want 0 0 0", rec_ready, letter_cnt, word);
    end
    game_rdy = 1'b1;
    step();
    send(8'h08);
    checks++;
    if (bad_char !== 1'b0 || letter_cnt !== 3'd0) begin
      errors++;
      $display("FAIL noop_bs got bad=%b cnt=%0d want 0 0", bad_char, letter_cnt);
    end
    for (int i = 0; i < 5; i++) send(8'h61);
    send(8'h0D);
    game_rdy = 1'b0;
    step(); step(); step();
    checks++;
    if (word_valid !== 1'b1 || word !== 40'h6161616161) begin
      errors++;
      $display("FAIL drop_submit got v=%b w=%h want 1 6161616161", word_valid, word);
    end
    word_ack = 1'b1;
    step();
    word_ack = 1'b0;
    step();
    checks++;
    if (word_valid !== 1'b0 || rec_ready !== 1'b0 || word !== 40'h0) begin
      errors++;
      $display("FAIL drop_ack got v=%b rr=%b w=%h want 0 0 0", word_valid, rec_ready, word);
    end
  endtask

  task automatic test_reset_in_submit();
    game_rdy = 1'b1;
    step();
    for (int i = 0; i < 5; i++) send(8'h74);
    send(8'h0D);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    checks++;
    if ({rec_ready, word_valid, bad_char, err_LED} !== 4'b0000 || word !== 40'h0 ||
        letter_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rst_submit got flags=%b w=%h cnt=%0d want 0000 0 0",
               {rec_ready, word_valid, bad_char, err_LED}, word, letter_cnt);
    end
  endtask

`ifdef GUESS_RX_ECHO_EN
  task automatic test_echo();
    step();
    send(8'h71);
    checks++;
    if (echo_valid !== 1'b1 || echo_byte !== 8'h51) begin
      errors++;
      $display("FAIL echo_letter got v=%b b=%h want 1 51", echo_valid, echo_byte);
    end
    step();
    checks++;
    if (echo_valid !== 1'b0) begin
      errors++;
      $display("FAIL echo_pulse got %b want 0", echo_valid);
    end
    send(8'h08);
    checks++;
    if (echo_valid !== 1'b1 || echo_byte !== 8'h08) begin
      errors++;
      $display("FAIL echo_bs got v=%b b=%h want 1 08", echo_valid, echo_byte);
    end
    send(8'h31);
    checks++;
    if (echo_valid !== 1'b0) begin
      errors++;
      $display("FAIL echo_reject got %b want 0", echo_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_submit();
    test_backspace();
    test_bad_char();
    test_error();
    test_game_rdy_drop();
    test_reset_in_submit();
`ifdef GUESS_RX_ECHO_EN
    test_echo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
